// File: rtl/pio_pkg.sv
// pio_pkg: shared PIO widths, sequencer state encoding and opcode constants
package pio_pkg;
    localparam int PIO_ADDR_W  = 5;
    localparam int PIO_DELAY_W = 5;
    typedef enum logic {EXEC = 1'b0, DELAY = 1'b1} seq_state_t;
    localparam logic [2:0] OP_JMP  = 3'd0;
    localparam logic [2:0] OP_WAIT = 3'd1;
    localparam logic [2:0] OP_IN   = 3'd2;
    localparam logic [2:0] OP_OUT  = 3'd3;
    localparam logic [2:0] OP_PUSH = 3'd4;
    localparam logic [2:0] OP_MOV  = 3'd5;
    localparam logic [2:0] OP_IRQ  = 3'd6;
    localparam logic [2:0] OP_SET  = 3'd7;
endpackage

// File: rtl/pio_pc_sequencer_if.sv
// pio_pc_sequencer_if: decoder/executor-facing signals of the PC sequencer
interface pio_pc_sequencer_if #(
    parameter int ADDR_W  = pio_pkg::PIO_ADDR_W,
    parameter int DELAY_W = pio_pkg::PIO_DELAY_W
) ();
    logic [DELAY_W-1:0] delay;
    logic               jmp;
    logic [ADDR_W-1:0]  jmp_addr;
    logic               stall;
    logic [ADDR_W-1:0]  pc;
    logic               issue;
    logic               delaying;
    logic               done;
    modport master (input delay, jmp, jmp_addr, stall, output pc, issue, delaying, done);
    modport slave  (output delay, jmp, jmp_addr, stall, input pc, issue, delaying, done);
endinterface

// File: rtl/pio_pc_sequencer.sv
// pio_pc_sequencer: per-state-machine program counter with wrap, jump, stall and delay phases
module pio_pc_sequencer
    import pio_pkg::*;
#(
    parameter int ADDR_W  = PIO_ADDR_W,
    parameter int DELAY_W = PIO_DELAY_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              restart,
    input  logic [ADDR_W-1:0] wrap_target,
    input  logic [ADDR_W-1:0] wrap_top,
    input  logic              force_pc,
    input  logic [ADDR_W-1:0] force_addr,
    pio_pc_sequencer_if.master bus
);
    seq_state_t         state, state_n;
    logic [ADDR_W-1:0]  pc_n, pending, pending_n, nxt;
    logic [DELAY_W-1:0] cnt, cnt_n;
    logic               done_n;

    assign nxt = bus.jmp ? bus.jmp_addr : (bus.pc == wrap_top) ? wrap_target : bus.pc + 1'b1;
    assign bus.issue = en & (state == EXEC);

    always_comb begin
        state_n   = state;
        pc_n      = bus.pc;
        pending_n = pending;
        cnt_n     = cnt;
        done_n    = 1'b0;
        if (force_pc) begin
            pc_n      = force_addr;
            pending_n = '0;
            cnt_n     = '0;
            state_n   = EXEC;
        end else if (restart) begin
            pending_n = '0;
            cnt_n     = '0;
            state_n   = EXEC;
        end else if (en && state == EXEC && !bus.stall) begin
            if (bus.delay == '0) begin
                pc_n   = nxt;
                done_n = 1'b1;
            end else begin
                pending_n = nxt;
                cnt_n     = bus.delay;
                state_n   = DELAY;
            end
        end else if (en && state == DELAY) begin
            // the last delay cycle retires the instruction and moves to the saved address
            if (cnt > 1) cnt_n = cnt - 1'b1;
            else begin
                pc_n    = pending;
                cnt_n   = '0;
                done_n  = 1'b1;
                state_n = EXEC;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= EXEC;
            bus.pc       <= '0;
            pending      <= '0;
            cnt          <= '0;
            bus.delaying <= 1'b0;
            bus.done     <= 1'b0;
        end else begin
            state        <= state_n;
            bus.pc       <= pc_n;
            pending      <= pending_n;
            cnt          <= cnt_n;
            bus.delaying <= (state_n == DELAY);
            bus.done     <= done_n;
        end
    end
endmodule
